// File: rtl/alu_resp_checker.sv
// alu_resp_checker: on-chip masked compare of alu responses with pattern/fail counters and first-fail capture.
// Define ALU_RESP_MISR_EN to build the 16-bit response MISR on sig; otherwise sig is tied to 0.
module alu_resp_checker #(
   parameter int NOUT = 2,
   parameter int PATW = 16,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            strobe,
   input  logic            last,
   input  logic [NOUT-1:0] zout,
   input  logic [NOUT-1:0] xpct,
   input  logic [NOUT-1:0] mask,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            err_pulse,
   output logic [PATW-1:0] pat_cnt,
   output logic [CNTW-1:0] fail_cnt,
   output logic [PATW-1:0] first_fail_pat,
   output logic [NOUT-1:0] first_fail_bits,
   output logic            first_fail_vld,
   output logic [15:0]     sig
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   localparam logic [31:0] FMAX = (32'd1 << CNTW) - 32'd1;
   state_e state_q, state_d;
   logic [PATW-1:0] pat_cnt_q, pat_cnt_d, ffp_q, ffp_d;
   logic [CNTW-1:0] fail_cnt_q, fail_cnt_d;
   logic [NOUT-1:0] ffb_q, ffb_d, miss;
   logic            ffv_q, ffv_d, err_q, err_d, acc;
   logic [31:0]     pop, sum;
   assign acc  = (state_q == RUN) && strobe && !start;
   assign miss = (zout ^ xpct) & mask;
   always_comb begin
      pop = '0;
      for (int i = 0; i < NOUT; i++) pop = pop + 32'(miss[i]);
   end
   assign sum = 32'(fail_cnt_q) + pop;
   always_comb begin
      state_d    = state_q;
      pat_cnt_d  = pat_cnt_q;
      fail_cnt_d = fail_cnt_q;
      ffp_d      = ffp_q;
      ffb_d      = ffb_q;
      ffv_d      = ffv_q;
      err_d      = 1'b0;
      if (start) begin
         state_d    = RUN;
         pat_cnt_d  = '0;
         fail_cnt_d = '0;
         ffp_d      = '0;
         ffb_d      = '0;
         ffv_d      = 1'b0;
      end else if (acc) begin
         pat_cnt_d  = (pat_cnt_q == '1) ? pat_cnt_q : pat_cnt_q + 1'b1;
         fail_cnt_d = (sum > FMAX) ? FMAX[CNTW-1:0] : sum[CNTW-1:0];
         err_d      = |miss;
         if (|miss && !ffv_q) begin
            ffp_d = pat_cnt_q;
            ffb_d = miss;
            ffv_d = 1'b1;
         end
         if (last) state_d = DONE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pat_cnt_q  <= '0;
         fail_cnt_q <= '0;
         ffp_q      <= '0;
         ffb_q      <= '0;
         ffv_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pat_cnt_q  <= pat_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         ffp_q      <= ffp_d;
         ffb_q      <= ffb_d;
         ffv_q      <= ffv_d;
         err_q      <= err_d;
      end
   end
`ifdef ALU_RESP_MISR_EN
   logic [15:0] sig_q, sig_d, mix;
   assign mix = 16'(zout & mask);
   always_comb begin
      sig_d = sig_q;
      if (start) sig_d = '0;
      else if (acc) sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ mix;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_q <= '0;
      else sig_q <= sig_d;
   end
   assign sig = sig_q;
`else
   assign sig = '0;
`endif
   assign busy            = (state_q == RUN);
   assign done            = (state_q == DONE);
   assign pass            = done && (fail_cnt_q == '0);
   assign err_pulse       = err_q;
   assign pat_cnt         = pat_cnt_q;
   assign fail_cnt        = fail_cnt_q;
   assign first_fail_pat  = ffp_q;
   assign first_fail_bits = ffb_q;
   assign first_fail_vld  = ffv_q;
endmodule

// File: tb/tb_alu_resp_checker.sv
// tb_alu_resp_checker: directed checks of alu_resp_checker (default widths plus a CNTW=2 instance for saturation).
module tb_alu_resp_checker;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, strobe = 1'b0, last = 1'b0;
   logic [1:0] zout = '0, xpct = '0, mask = '0;
   logic busy, done, pass, err_pulse, ffv;
   logic [15:0] pat_cnt, ffp, sig;
   logic [7:0] fail_cnt;
   logic [1:0] ffb;
   logic b_busy, b_done, b_pass, b_err, b_ffv;
   logic [15:0] b_pat, b_ffp, b_sig;
   logic [1:0] b_fail, b_ffb;
   int tests = 0, failed = 0;
`ifdef ALU_RESP_MISR_EN
   localparam logic [15:0] SIG_GOLD = 16'h0012, SIG_FLIP = 16'h0002;
`else
   localparam logic [15:0] SIG_GOLD = 16'h0000, SIG_FLIP = 16'h0000;
`endif
   always #5 clk = ~clk;
   alu_resp_checker dut (
      .clk(clk), .rst(rst), .start(start), .strobe(strobe), .last(last),
      .zout(zout), .xpct(xpct), .mask(mask), .busy(busy), .done(done), .pass(pass),
      .err_pulse(err_pulse), .pat_cnt(pat_cnt), .fail_cnt(fail_cnt), .first_fail_pat(ffp),
      .first_fail_bits(ffb), .first_fail_vld(ffv), .sig(sig)
   );
   alu_resp_checker #(.CNTW(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .strobe(strobe), .last(last),
      .zout(zout), .xpct(xpct), .mask(mask), .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_pulse(b_err), .pat_cnt(b_pat), .fail_cnt(b_fail), .first_fail_pat(b_ffp),
      .first_fail_bits(b_ffb), .first_fail_vld(b_ffv), .sig(b_sig)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic pat(input logic [1:0] z, input logic [1:0] x, input logic [1:0] m, input logic l);
      zout = z; xpct = x; mask = m; last = l; strobe = 1'b1;
      @(posedge clk); #1;
      strobe = 1'b0; last = 1'b0;
   endtask
   task automatic go();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask
   initial begin
      #3;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_err", 32'(err_pulse), 0);
      chk("rst_pat", 32'(pat_cnt), 0);
      chk("rst_fail", 32'(fail_cnt), 0);
      chk("rst_ffp", 32'(ffp), 0);
      chk("rst_ffb", 32'(ffb), 0);
      chk("rst_ffv", 32'(ffv), 0);
      chk("rst_sig", 32'(sig), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      pat(2'b11, 2'b00, 2'b11, 1'b1);
      chk("idle_strobe_pat", 32'(pat_cnt), 0);
      chk("idle_strobe_err", 32'(err_pulse), 0);
      chk("idle_strobe_busy", 32'(busy), 0);
      go();
      chk("gold_busy", 32'(busy), 1);
      pat(2'b10, 2'b10, 2'b11, 1'b0);
      chk("gold_err0", 32'(err_pulse), 0);
      pat(2'b00, 2'b00, 2'b11, 1'b0);
      chk("gold_err1", 32'(err_pulse), 0);
      pat(2'b01, 2'b01, 2'b11, 1'b0);
      chk("gold_err2", 32'(err_pulse), 0);
      chk("gold_busy_mid", 32'(busy), 1);
      pat(2'bx0, 2'bx0, 2'b01, 1'b1);
      chk("gold_err3", 32'(err_pulse), 0);
      chk("gold_pat", 32'(pat_cnt), 4);
      chk("gold_fail", 32'(fail_cnt), 0);
      chk("gold_done", 32'(done), 1);
      chk("gold_busy_end", 32'(busy), 0);
      chk("gold_pass", 32'(pass), 1);
      chk("gold_ffv", 32'(ffv), 0);
      chk("gold_sig", 32'(sig), 32'(SIG_GOLD));
      pat(2'b11, 2'b00, 2'b11, 1'b0);
      chk("done_strobe_pat", 32'(pat_cnt), 4);
      chk("done_strobe_fail", 32'(fail_cnt), 0);
      chk("done_strobe_err", 32'(err_pulse), 0);
      chk("done_strobe_sig", 32'(sig), 32'(SIG_GOLD));
      chk("done_strobe_pass", 32'(pass), 1);
      go();
      chk("miss_cleared_pat", 32'(pat_cnt), 0);
      pat(2'b10, 2'b10, 2'b11, 1'b0);
      pat(2'b00, 2'b00, 2'b11, 1'b0);
      chk("miss_err_before", 32'(err_pulse), 0);
      pat(2'b11, 2'b01, 2'b11, 1'b0);
      chk("miss_err", 32'(err_pulse), 1);
      chk("miss_fail", 32'(fail_cnt), 1);
      chk("miss_ffp", 32'(ffp), 2);
      chk("miss_ffb", 32'(ffb), 2);
      chk("miss_ffv", 32'(ffv), 1);
      pat(2'bx0, 2'bx0, 2'b01, 1'b1);
      chk("miss_err_once", 32'(err_pulse), 0);
      chk("miss_done", 32'(done), 1);
      chk("miss_pass", 32'(pass), 0);
      chk("miss_pat", 32'(pat_cnt), 4);
      chk("miss_fail_end", 32'(fail_cnt), 1);
      go();
      chk("mask_ffv_clr", 32'(ffv), 0);
      pat(2'b11, 2'b00, 2'b01, 1'b0);
      chk("mask01_fail", 32'(fail_cnt), 1);
      chk("mask01_ffb", 32'(ffb), 1);
      chk("mask01_ffp", 32'(ffp), 0);
      pat(2'b11, 2'b00, 2'b00, 1'b0);
      chk("mask00_err", 32'(err_pulse), 0);
      chk("mask00_fail", 32'(fail_cnt), 1);
      chk("mask00_pat", 32'(pat_cnt), 2);
      go();
      for (int i = 0; i < 5; i++) pat(2'b11, 2'b00, 2'b11, 1'b0);
      chk("sat_fail2", 32'(b_fail), 3);
      chk("sat_ffp2", 32'(b_ffp), 0);
      chk("sat_ffb2", 32'(b_ffb), 3);
      chk("sat_fail8", 32'(fail_cnt), 10);
      chk("sat_pat", 32'(pat_cnt), 5);
      go();
      chk("restart_pat", 32'(pat_cnt), 0);
      chk("restart_fail", 32'(fail_cnt), 0);
      chk("restart_ffv", 32'(ffv), 0);
      chk("restart_busy", 32'(busy), 1);
      pat(2'b11, 2'b00, 2'b11, 1'b0);
      start = 1'b1;
      pat(2'b11, 2'b00, 2'b11, 1'b0);
      start = 1'b0;
      chk("start_strobe_pat", 32'(pat_cnt), 0);
      chk("start_strobe_fail", 32'(fail_cnt), 0);
      chk("start_strobe_err", 32'(err_pulse), 0);
      chk("start_strobe_busy", 32'(busy), 1);
      go();
      pat(2'b00, 2'b10, 2'b11, 1'b0);
      pat(2'b00, 2'b00, 2'b11, 1'b0);
      pat(2'b01, 2'b01, 2'b11, 1'b0);
      pat(2'bx0, 2'bx0, 2'b01, 1'b1);
      chk("flip_sig", 32'(sig), 32'(SIG_FLIP));
      chk("flip_fail", 32'(fail_cnt), 1);
      chk("flip_ffp", 32'(ffp), 0);
      go();
      pat(2'b11, 2'b00, 2'b11, 1'b0);
      chk("arst_pre_pat", 32'(pat_cnt), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_pat", 32'(pat_cnt), 0);
      chk("arst_fail", 32'(fail_cnt), 0);
      chk("arst_ffv", 32'(ffv), 0);
      chk("arst_ffb", 32'(ffb), 0);
      chk("arst_err", 32'(err_pulse), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_sig", 32'(sig), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
